// File: rtl/matrix_pkg.sv
// Shared fixed-point matrix types and helpers for the 4x4 transform blocks.
package matrix_pkg;

   localparam int unsigned FXP_W = 16;

   typedef logic signed [FXP_W-1:0] fxp_t;
   typedef logic [15:0][15:0]       mat4_t;

   typedef enum logic [1:0] {
      IDLE,
      COMPUTE,
      DONE
   } state_e;

   // Row-major element index: 4*row + col.
   function automatic logic [3:0] idx(input logic [1:0] row, input logic [1:0] col);
      return {row, col};
   endfunction

   function automatic fxp_t fxp_one(input int unsigned frac);
      return fxp_t'(FXP_W'(32'd1 << frac));
   endfunction

   // Rotation transposed, translation cleared, bottom row set to [0 0 0 1].
   function automatic mat4_t init_inverse(input mat4_t m, input fxp_t one);
      mat4_t res;
      res = '0;
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 3; c++) begin
            res[idx(2'(r), 2'(c))] = m[idx(2'(c), 2'(r))];
         end
      end
      res[idx(2'd3, 2'd3)] = one;
      return res;
   endfunction

endpackage

// File: rtl/fxp_sat_mac.sv
// Signed 16x16 multiply with 34-bit accumulate; the output stage returns
// sat16(-(acc + product) >>> FRAC) and flags clamping.
module fxp_sat_mac
   import matrix_pkg::*;
#(
   parameter int unsigned FRAC = 8
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   input  logic last_i,
   input  fxp_t a_i,
   input  fxp_t b_i,
   output fxp_t res_o,
   output logic ovf_o
);

   logic signed [31:0] prod;
   logic signed [33:0] acc_q, acc_d, sum, neg, shifted;

   always_comb begin
      prod    = 32'(a_i) * 32'(b_i);
      sum     = acc_q + 34'(prod);
      neg     = -sum;
      shifted = neg >>> FRAC;
      ovf_o   = 1'b0;
      if (shifted > 34'sd32767) begin
         res_o = 16'sh7FFF;
         ovf_o = 1'b1;
      end else if (shifted < -34'sd32768) begin
         res_o = 16'sh8000;
         ovf_o = 1'b1;
      end else begin
         res_o = shifted[FXP_W-1:0];
      end
   end

   // The final product of a dot product is consumed combinationally, so the
   // accumulator restarts from zero on the same edge.
   always_comb begin
      acc_d = acc_q;
      if (clr_i || (en_i && last_i)) begin
         acc_d = '0;
      end else if (en_i) begin
         acc_d = sum;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/affine_inverse.sv
// Rigid-body 4x4 inverse: transposes R at accept, then computes -R^T*t with
// one shared MAC over nine cycles.
module affine_inverse
   import matrix_pkg::*;
#(
   parameter int unsigned FRAC = 8
) (
   input  logic  Clk,
   input  logic  Reset_n,
   input  logic  in_valid,
   output logic  in_ready,
   input  mat4_t mat_in,
   output logic  out_valid,
   input  logic  out_ready,
   output mat4_t mat_out,
   output logic  ovf
);

   state_e            state_q, state_d;
   logic [11:0][15:0] cap_q, cap_d;
   mat4_t             mat_out_q, mat_out_d;
   logic              ovf_q, ovf_d;
   logic [1:0]        r_q, r_d, k_q, k_d;
   logic              load;
   logic              mac_clr, mac_en, mac_last, mac_ovf;
   fxp_t              mac_a, mac_b, mac_res;

   // The bottom input row never affects the result.
   logic unused_mat_in;
   assign unused_mat_in = ^mat_in[15:12];

   assign mac_a = cap_q[idx(k_q, r_q)];
   assign mac_b = cap_q[idx(k_q, 2'd3)];

   fxp_sat_mac #(
      .FRAC (FRAC)
   ) u_mac (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .clr_i  (mac_clr),
      .en_i   (mac_en),
      .last_i (mac_last),
      .a_i    (mac_a),
      .b_i    (mac_b),
      .res_o  (mac_res),
      .ovf_o  (mac_ovf)
   );

   always_comb begin
      state_d   = state_q;
      cap_d     = cap_q;
      mat_out_d = mat_out_q;
      ovf_d     = ovf_q;
      r_d       = r_q;
      k_d       = k_q;
      in_ready  = 1'b0;
      load      = 1'b0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      mac_last  = 1'b0;

      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            load     = in_valid;
         end
         COMPUTE: begin
            mac_en   = 1'b1;
            mac_last = (k_q == 2'd2);
            if (mac_last) begin
               mat_out_d[idx(r_q, 2'd3)] = mac_res;
               ovf_d = ovf_q | mac_ovf;
               k_d   = 2'd0;
               if (r_q == 2'd2) begin
                  r_d     = 2'd0;
                  state_d = DONE;
               end else begin
                  r_d = r_q + 2'd1;
               end
            end else begin
               k_d = k_q + 2'd1;
            end
         end
         DONE: begin
            in_ready = out_ready;
            if (out_ready) begin
               load    = in_valid;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (load) begin
         cap_d     = mat_in[11:0];
         mat_out_d = init_inverse(mat_in, fxp_one(FRAC));
         ovf_d     = 1'b0;
         r_d       = 2'd0;
         k_d       = 2'd0;
         mac_clr   = 1'b1;
         state_d   = COMPUTE;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state_q   <= IDLE;
         cap_q     <= '0;
         mat_out_q <= '0;
         ovf_q     <= 1'b0;
         r_q       <= 2'd0;
         k_q       <= 2'd0;
      end else begin
         state_q   <= state_d;
         cap_q     <= cap_d;
         mat_out_q <= mat_out_d;
         ovf_q     <= ovf_d;
         r_q       <= r_d;
         k_q       <= k_d;
      end
   end

   assign out_valid = (state_q == DONE);
   assign mat_out   = mat_out_q;
   assign ovf       = ovf_q;

endmodule
